// File: rtl/panda_tb_pkg.sv
// PandA test environment shared definitions.
// Widths, default timing and IRQ flag bit positions.
package panda_tb_pkg;

  localparam int TTL_W            = 6;
  localparam int RESET_CYCLES_DEF = 16;
  localparam int TTL_PERIOD_DEF   = 8;

  localparam int IRQ_ARMED_BIT    = 0;
  localparam int IRQ_DONE_BIT     = 1;
  localparam int IRQ_DMA_BLK_BIT  = 2;

  localparam logic [31:0] SMPL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/panda_tb_if.sv
// S_AXI_HP0 write-beat stream between the DMA source and the env.
// Master drives beats; slave returns ready.
interface panda_tb_if;

  logic        wvalid;
  logic [31:0] wdata;
  logic        wready;

  modport master (
    output wvalid,
    output wdata,
    input  wready
  );

  modport slave (
    input  wvalid,
    input  wdata,
    output wready
  );

endinterface

// File: rtl/panda_tb_reset_seq.sv
// Stretched reset for the PS model and UUT.
// Holds tb reset low for RESET_CYCLES clocks after rst_n rises.
module panda_tb_reset_seq
  import panda_tb_pkg::*;
#(
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tb_rst_n_o
);

  localparam int CW = $clog2(RESET_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(RESET_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // count up to the last cycle, then latch release
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q | (cnt_q == LAST);
    if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  // sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign tb_rst_n_o = done_q;

endmodule

// File: rtl/panda_top_tb_env.sv
// Clocked stimulus/monitor env around the PandA top level.
// Drives TTL pads while armed, sinks DMA beats, counts IRQs.
module panda_top_tb_env
  import panda_tb_pkg::*;
#(
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int TTL_PERIOD   = TTL_PERIOD_DEF,
  parameter int NUM_TTL      = TTL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pcap_armed_i,
  input  logic               irq_i,
  input  logic [31:0]        irq_status_i,
  panda_tb_if.slave          hp0,
  output logic               tb_aresetn_o,
  output logic [NUM_TTL-1:0] ttlin_pad_o,
  output logic [31:0]        smpl_count_o,
  output logic [15:0]        irq_count_o,
  output logic [7:0]         irq_flags_o,
  output logic [31:0]        last_sample_o,
  output logic               pcap_completed_o
);

  localparam int DW = $clog2(TTL_PERIOD) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TTL_PERIOD - 1);

  logic               run;
  logic               rise, fall, accept, irq_rise;
  logic               armed_q, armed_d;
  logic               irq_q, irq_d;
  logic [DW-1:0]      div_q, div_d;
  logic [NUM_TTL-1:0] ttl_q, ttl_d;
  logic [31:0]        smpl_q, smpl_d;
  logic [31:0]        last_q, last_d;
  logic [15:0]        icnt_q, icnt_d;
  logic [7:0]         flags_q, flags_d;
  logic               comp_q, comp_d;
  logic               unused_status;

  panda_tb_reset_seq #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_rst (
    .clk       (clk),
    .rst_n     (rst_n),
    .tb_rst_n_o(run)
  );

  assign rise     = run & pcap_armed_i & ~armed_q;
  assign fall     = run & ~pcap_armed_i & armed_q;
  assign accept   = run & hp0.wvalid;
  assign irq_rise = run & irq_i & ~irq_q;

  assign unused_status = ^irq_status_i[31:8];

  // next state: edge detect, TTL divider, counters
  always_comb begin
    armed_d = armed_q;
    irq_d   = irq_q;
    div_d   = div_q;
    ttl_d   = ttl_q;
    smpl_d  = smpl_q;
    last_d  = last_q;
    icnt_d  = icnt_q;
    flags_d = flags_q;
    comp_d  = comp_q;
    if (run) begin
      armed_d = pcap_armed_i;
      irq_d   = irq_i;
    end
    if (rise) begin
      div_d  = '0;
      ttl_d  = '0;
      smpl_d = '0;
      comp_d = 1'b0;
    end else if (run && pcap_armed_i) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        ttl_d = ttl_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end else begin
      div_d = '0;
      ttl_d = '0;
    end
    if (fall) comp_d = 1'b1;
    if (accept) begin
      last_d = hp0.wdata;
      if (smpl_d != SMPL_MAX) smpl_d = smpl_d + 32'd1;
    end
    if (irq_rise) begin
      icnt_d  = icnt_q + 16'd1;
      flags_d = irq_status_i[7:0];
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      irq_q   <= 1'b0;
      div_q   <= '0;
      ttl_q   <= '0;
      smpl_q  <= '0;
      last_q  <= '0;
      icnt_q  <= '0;
      flags_q <= '0;
      comp_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      irq_q   <= irq_d;
      div_q   <= div_d;
      ttl_q   <= ttl_d;
      smpl_q  <= smpl_d;
      last_q  <= last_d;
      icnt_q  <= icnt_d;
      flags_q <= flags_d;
      comp_q  <= comp_d;
    end
  end

  assign hp0.wready       = run;
  assign tb_aresetn_o     = run;
  assign ttlin_pad_o      = ttl_q;
  assign smpl_count_o     = smpl_q;
  assign last_sample_o    = last_q;
  assign irq_count_o      = icnt_q;
  assign irq_flags_o      = flags_q;
  assign pcap_completed_o = comp_q;

endmodule

// File: tb/tb_panda_top_tb_env.sv
// Scoreboard bench for panda_top_tb_env.
// Reference model predicts every cycle; monitor compares.
module tb_panda_top_tb_env;

  localparam int RC  = 16;
  localparam int TP  = 8;
  localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

  typedef struct {
    logic        tb;
    logic        rdy;
    logic [5:0]  ttl;
    logic [31:0] smpl;
    logic [15:0] ic;
    logic [7:0]  fl;
    logic [31:0] last;
    logic        comp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pcap_armed;
  logic        irq;
  logic [31:0] irq_status;
  logic        tb_aresetn;
  logic [5:0]  ttlin_pad;
  logic [31:0] smpl_count;
  logic [15:0] irq_count;
  logic [7:0]  irq_flags;
  logic [31:0] last_sample;
  logic        pcap_completed;

  panda_tb_if hp0 ();

  panda_top_tb_env dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pcap_armed_i    (pcap_armed),
    .irq_i           (irq),
    .irq_status_i    (irq_status),
    .hp0             (hp0.slave),
    .tb_aresetn_o    (tb_aresetn),
    .ttlin_pad_o     (ttlin_pad),
    .smpl_count_o    (smpl_count),
    .irq_count_o     (irq_count),
    .irq_flags_o     (irq_flags),
    .last_sample_o   (last_sample),
    .pcap_completed_o(pcap_completed)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;
  exp_t sb[$];

  // reference model state
  int          m_rel = 0;
  int          m_age = 0;
  logic        m_arm_prev = 0;
  logic        m_irq_prev = 0;
  logic        m_tb = 0;
  logic [5:0]  m_ttl = 0;
  logic [31:0] m_smpl = 0;
  logic [31:0] m_last = 0;
  logic [15:0] m_ic = 0;
  logic [7:0]  m_fl = 0;
  logic        m_comp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_edge();
    bit active;
    if (!rst_n) begin
      m_rel = 0; m_age = 0; m_arm_prev = 0; m_irq_prev = 0;
      m_tb = 0; m_ttl = 0; m_smpl = 0; m_last = 0;
      m_ic = 0; m_fl = 0; m_comp = 0;
      return;
    end
    active = (m_rel >= RC);
    if (m_rel < 1000) m_rel++;
    if (active) begin
      if (pcap_armed && !m_arm_prev) begin
        m_age = 0; m_smpl = 0; m_comp = 0;
      end else if (pcap_armed) begin
        m_age++;
      end
      if (!pcap_armed && m_arm_prev) m_comp = 1;
      m_arm_prev = pcap_armed;
      m_ttl = pcap_armed ? 6'((m_age / TP) % 64) : 6'd0;
      if (hp0.wvalid) begin
        if (m_smpl != MAXV) m_smpl = m_smpl + 1;
        m_last = hp0.wdata;
      end
      if (irq && !m_irq_prev) begin
        m_ic = m_ic + 16'd1;
        m_fl = irq_status[7:0];
      end
      m_irq_prev = irq;
    end
    m_tb = (m_rel >= RC);
  endfunction

  task automatic cyc();
    exp_t e;
    model_edge();
    e.tb = m_tb; e.rdy = m_tb; e.ttl = m_ttl; e.smpl = m_smpl;
    e.ic = m_ic; e.fl = m_fl; e.last = m_last; e.comp = m_comp;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // monitor: compare DUT outputs after each edge against queued model
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cyc++;
        chk($sformatf("c%0d tb_aresetn", n_cyc), 32'(tb_aresetn), 32'(e.tb));
        chk($sformatf("c%0d wready", n_cyc), 32'(hp0.wready), 32'(e.rdy));
        chk($sformatf("c%0d ttlin_pad", n_cyc), 32'(ttlin_pad), 32'(e.ttl));
        chk($sformatf("c%0d smpl_count", n_cyc), smpl_count, e.smpl);
        chk($sformatf("c%0d irq_count", n_cyc), 32'(irq_count), 32'(e.ic));
        chk($sformatf("c%0d irq_flags", n_cyc), 32'(irq_flags), 32'(e.fl));
        chk($sformatf("c%0d last_sample", n_cyc), last_sample, e.last);
        chk($sformatf("c%0d completed", n_cyc), 32'(pcap_completed), 32'(e.comp));
      end
    end
  end

  initial begin
    rst_n = 1'b0; pcap_armed = 1'b0; irq = 1'b0; irq_status = '0;
    hp0.wvalid = 1'b0; hp0.wdata = '0;
    @(negedge clk);
    cycles(3);
    chk("rst tb_aresetn", 32'(tb_aresetn), 32'd0);
    chk("rst wready", 32'(hp0.wready), 32'd0);

    // reset sequence: exactly 16 edges low
    rst_n = 1'b1;
    cycles(15);
    chk("seq low at 15", 32'(tb_aresetn), 32'd0);
    cycles(1);
    chk("seq high at 16", 32'(tb_aresetn), 32'd1);
    cycles(4);

    // arm and TTL stepping
    pcap_armed = 1'b1;
    cycles(40);
    chk("ttl after 40", 32'(ttlin_pad), 32'd4);
    pcap_armed = 1'b0;
    cycles(1);
    chk("disarm ttl", 32'(ttlin_pad), 32'd0);
    chk("disarm completed", 32'(pcap_completed), 32'd1);
    cycles(2);

    // DMA 1000 beats
    for (int i = 0; i < 1000; i++) begin
      hp0.wvalid = 1'b1; hp0.wdata = 32'(i);
      cyc();
    end
    hp0.wvalid = 1'b0;
    cycles(1);
    chk("dma count", smpl_count, 32'd1000);
    chk("dma last", last_sample, 32'd999);

    // re-arm clears
    pcap_armed = 1'b1;
    cycles(1);
    chk("rearm smpl", smpl_count, 32'd0);
    chk("rearm completed", 32'(pcap_completed), 32'd0);
    pcap_armed = 1'b0;
    cycles(2);

    // IRQ pulses then a held level
    begin
      logic [7:0] st [3];
      st[0] = 8'h01; st[1] = 8'h04; st[2] = 8'h02;
      for (int i = 0; i < 3; i++) begin
        irq = 1'b1; irq_status = {24'h0, st[i]};
        cyc();
        irq = 1'b0;
        cycles(2);
      end
    end
    chk("irq count", 32'(irq_count), 32'd3);
    chk("irq flags", 32'(irq_flags), 32'h02);
    irq = 1'b1; irq_status = 32'hAB;
    cycles(6);
    irq = 1'b0;
    cycles(1);
    chk("irq held once", 32'(irq_count), 32'd4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(29) == 0) pcap_armed = ~pcap_armed;
      if ($urandom_range(3) == 0) irq = ~irq;
      irq_status = $urandom;
      hp0.wvalid = 1'($urandom);
      hp0.wdata = $urandom;
      cyc();
    end
    pcap_armed = 1'b0; irq = 1'b0; hp0.wvalid = 1'b0;
    cycles(2);

    // saturation from a preset near max
    dut.smpl_q = 32'hFFFF_FFFC;
    m_smpl = 32'hFFFF_FFFC;
    hp0.wvalid = 1'b1; hp0.wdata = 32'h5A5A_0001;
    cycles(6);
    hp0.wvalid = 1'b0;
    cycles(1);
    chk("smpl saturates", smpl_count, MAXV);

    // TTL wrap 63 -> 0
    pcap_armed = 1'b1;
    cycles(512);
    chk("ttl at 63", 32'(ttlin_pad), 32'd63);
    cycles(1);
    chk("ttl wraps", 32'(ttlin_pad), 32'd0);
    cycles(20);

    // mid-arm reset pulse
    rst_n = 1'b0;
    #1;
    chk("async tb_aresetn", 32'(tb_aresetn), 32'd0);
    chk("async ttl", 32'(ttlin_pad), 32'd0);
    chk("async irq_count", 32'(irq_count), 32'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(15);
    chk("relaunch low", 32'(tb_aresetn), 32'd0);
    cycles(1);
    chk("relaunch high", 32'(tb_aresetn), 32'd1);
    hp0.wvalid = 1'b1; hp0.wdata = 32'h1234;
    cycles(20);
    hp0.wvalid = 1'b0;
    cycles(2);

    chk("queue drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
